// File: rtl/rf_alu_pkg.sv
// Shared widths and one-hot ALU operation bit indices for register_file_alu.
package rf_alu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  localparam int ALU_OPS  = 10;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 5;
  localparam int ALU_SRL  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_SLT  = 8;
  localparam int ALU_SLTU = 9;

endpackage

// File: rtl/register_file_alu_dec3to8.sv
// Combinational 3-to-8 one-hot decoder used for the funct3 field.
module dec3to8 (
  input  logic [2:0] sel_i,
  output logic [7:0] dec_o
);

  always_comb begin
    // NOTE: default first so every path assigns dec_o and no latch is inferred.
    dec_o = '0;
    dec_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/register_file_alu.sv
// Two-read/one-write register file (x0 hardwired to zero), one-hot ALU and funct3 decoder.
// Optional macro RF_WRITE_BYPASS_EN forwards same-cycle write data to the read ports.
module register_file_alu
  import rf_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [AW-1:0]       raddr1,
  input  logic [AW-1:0]       raddr2,
  output logic [XLEN-1:0]     rdata1,
  output logic [XLEN-1:0]     rdata2,
  input  logic [XLEN-1:0]     alu_src1,
  input  logic [XLEN-1:0]     alu_src2,
  input  logic [ALU_OPS-1:0]  alu_op,
  output logic [XLEN-1:0]     alu_result,
  input  logic [2:0]          funct3,
  output logic [7:0]          funct3_d
);

  localparam int NREGS = 2 ** AW;

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = wen && (waddr != '0);

  // NOTE: the register array is reset explicitly because software relies on
  // every register reading zero after reset; reset also wins over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        // NOTE: non-blocking for all sequential state, including array entries.
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = (addr == '0) ? '0 : regs_q[addr];
`ifdef RF_WRITE_BYPASS_EN
    if (wr_en && !reset && (addr == waddr)) begin
      val = wdata;
    end
`endif
    return val;
  endfunction

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);

  // Shift amount is always the low five bits of src2, independent of XLEN.
  logic [4:0] shamt;
  assign shamt = alu_src2[4:0];

  // AND-OR mux: each selected operation contributes its result; none selected gives 0.
  always_comb begin
    alu_result = '0;
    if (alu_op[ALU_ADD])  alu_result |= alu_src1 + alu_src2;
    if (alu_op[ALU_SUB])  alu_result |= alu_src1 - alu_src2;
    if (alu_op[ALU_AND])  alu_result |= alu_src1 & alu_src2;
    if (alu_op[ALU_OR])   alu_result |= alu_src1 | alu_src2;
    if (alu_op[ALU_XOR])  alu_result |= alu_src1 ^ alu_src2;
    if (alu_op[ALU_SLL])  alu_result |= alu_src1 << shamt;
    if (alu_op[ALU_SRL])  alu_result |= alu_src1 >> shamt;
    if (alu_op[ALU_SRA])  alu_result |= XLEN'($signed(alu_src1) >>> shamt);
    if (alu_op[ALU_SLT])  alu_result |= {{(XLEN-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
    if (alu_op[ALU_SLTU]) alu_result |= {{(XLEN-1){1'b0}}, alu_src1 < alu_src2};
  end

  dec3to8 u_funct3_dec (
    .sel_i (funct3),
    .dec_o (funct3_d)
  );

endmodule

// File: tb/tb_register_file_alu.sv
// Directed self-checking bench for register_file_alu: reset, writes, x0, read-during-write,
// ALU corner cases, decoder sweep and reset-over-write priority.
module tb_register_file_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic [31:0] alu_src1, alu_src2;
  logic [9:0]  alu_op;
  logic [31:0] alu_result;
  logic [2:0]  funct3;
  logic [7:0]  funct3_d;

  int checks = 0;
  int errors = 0;

  register_file_alu dut (
    .clk        (clk),
    .reset      (reset),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .funct3     (funct3),
    .funct3_d   (funct3_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string tag);
    alu_op = op; alu_src1 = a; alu_src2 = b;
    #1;
    check(tag, alu_result, exp);
  endtask

  initial begin
    reset = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; alu_src1 = '0; alu_src2 = '0; alu_op = '0; funct3 = '0;
    tick();
    tick();
    reset = 1'b0;

    // Every register reads zero on both ports after reset
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      check($sformatf("rst_r1_x%0d", i), rdata1, 32'h0);
      check($sformatf("rst_r2_x%0d", 31 - i), rdata2, 32'h0);
    end

    // x5 write lands, x0 write is dropped
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    waddr = 5'd0; wdata = 32'h12345678;
    tick();
    wen = 1'b0;
    raddr1 = 5'd5; raddr2 = 5'd0;
    #1;
    check("x5_read", rdata1, 32'hDEADBEEF);
    check("x0_read", rdata2, 32'h0);
    raddr2 = 5'd5;
    #1;
    check("same_addr_r1", rdata1, 32'hDEADBEEF);
    check("same_addr_r2", rdata2, 32'hDEADBEEF);

    // Read-during-write on x7: old value unless bypass is built in
    wen = 1'b1; waddr = 5'd7; wdata = 32'h00000011;
    tick();
    wdata = 32'h000000A5; raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("rdw_x7_r1", rdata1, 32'h000000A5);
    check("rdw_x7_r2", rdata2, 32'h000000A5);
`else
    check("rdw_x7_r1", rdata1, 32'h00000011);
    check("rdw_x7_r2", rdata2, 32'h00000011);
`endif
    tick();
    wen = 1'b0;
    #1;
    check("x7_after", rdata1, 32'h000000A5);

    // ALU corner cases and per-op sanity
    alu(10'b0000000001, 32'hFFFFFFFF, 32'h1,        32'h0,        "add_wrap");
    alu(10'b0000000001, 32'h00000007, 32'h5,        32'hC,        "add");
    alu(10'b0000000010, 32'h0,        32'h1,        32'hFFFFFFFF, "sub_wrap");
    alu(10'b0000000100, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, "and");
    alu(10'b0000001000, 32'hF0000000, 32'h0000000F, 32'hF000000F, "or");
    alu(10'b0000010000, 32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0, "xor");
    alu(10'b0000100000, 32'h00000001, 32'hFFFFFFE4, 32'h00000010, "sll_shamt_low5");
    alu(10'b0001000000, 32'h80000000, 32'h4,        32'h08000000, "srl");
    alu(10'b0010000000, 32'h80000000, 32'h4,        32'hF8000000, "sra");
    alu(10'b0010000000, 32'h40000000, 32'h4,        32'h04000000, "sra_pos");
    alu(10'b0100000000, 32'hFFFFFFFF, 32'h1,        32'h1,        "slt_neg");
    alu(10'b0100000000, 32'h1,        32'hFFFFFFFF, 32'h0,        "slt_pos");
    alu(10'b1000000000, 32'hFFFFFFFF, 32'h1,        32'h0,        "sltu_big");
    alu(10'b1000000000, 32'h1,        32'hFFFFFFFF, 32'h1,        "sltu_small");
    alu(10'b0000011000, 32'h0000000C, 32'h0000000A, 32'h0000000E, "multi_or_xor");
    alu(10'b0000000000, 32'h12345678, 32'h9ABCDEF0, 32'h0,        "op_zero");

    // funct3 decoder sweep
    for (int i = 0; i < 8; i++) begin
      funct3 = 3'(i);
      #1;
      check($sformatf("dec_%0d", i), {24'h0, funct3_d}, 32'h1 << i);
    end

    // Reset beats a simultaneous write; all stored data cleared
    wen = 1'b1; waddr = 5'd3; wdata = 32'h00000099;
    tick();
    raddr1 = 5'd3;
    #1;
    check("x3_pre", rdata1, 32'h00000099);
    reset = 1'b1; wdata = 32'h00000055;
    tick();
    reset = 1'b0; wen = 1'b0; raddr1 = 5'd3; raddr2 = 5'd5;
    #1;
    check("rst_prio_x3", rdata1, 32'h0);
    check("rst_clr_x5", rdata2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
